// File: rtl/uart_baud_gen_if.sv
// Rate selection, channel enables and timing strobes exchanged between the
// UART TX/RX datapath (master) and the baud-rate generator (slave).
interface uart_baud_gen_if;
    logic [2:0] baud_sel;
    logic       tx_en;
    logic       rx_en;
    logic       tx_tick;
    logic       rx_tick;
    logic       baud_lock;
    logic [2:0] cur_sel;

    modport master (
        output baud_sel, tx_en, rx_en,
        input  tx_tick, rx_tick, baud_lock, cur_sel
    );

    modport slave (
        input  baud_sel, tx_en, rx_en,
        output tx_tick, rx_tick, baud_lock, cur_sel
    );
endinterface

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: TX bit-boundary strobe and RX mid-bit strobe
// from a runtime-selected divisor that stays frozen while a frame is active.
module uart_baud_gen #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_SEL = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_baud_gen_if.slave bus
);
    localparam logic [2:0] DEF_SEL = 3'(DEFAULT_SEL);

    function automatic longint unsigned baud_of(input int sel);
        case (sel)
            0:       baud_of = 64'd2400;
            1:       baud_of = 64'd4800;
            2:       baud_of = 64'd9600;
            3:       baud_of = 64'd19200;
            4:       baud_of = 64'd38400;
            5:       baud_of = 64'd57600;
            6:       baud_of = 64'd115200;
            default: baud_of = 64'd230400;
        endcase
    endfunction

    function automatic longint unsigned div_of(input int sel);
        div_of = (longint'(CLK_HZ) + baud_of(sel) / 64'd2) / baud_of(sel);
    endfunction

    logic [CNT_W-1:0] div_tab  [8];
    logic [CNT_W-1:0] half_tab [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_tab
            localparam longint unsigned DIV_V = div_of(gi);
            if (DIV_V > ((64'd1 << CNT_W) - 64'd1)) begin : g_too_wide
                $error("uart_baud_gen: divisor for code %0d does not fit in CNT_W bits", gi);
            end
            assign div_tab[gi]  = CNT_W'(DIV_V);
            assign half_tab[gi] = CNT_W'(DIV_V / 64'd2);
        end
    endgenerate

    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] half_reg;
    logic [2:0]       cur_sel_reg;
    logic             lock_reg;
    logic [CNT_W-1:0] tx_cnt_reg;
    logic             tx_tick_reg;
    logic [CNT_W-1:0] rx_cnt_reg;
    logic             rx_first_reg;
    logic             rx_tick_reg;
    logic [CNT_W-1:0] rx_target;

    // The first RX strobe lands half a bit after start-bit detect, later ones a full bit apart.
    assign rx_target = rx_first_reg ? (half_reg - CNT_W'(1)) : (div_reg - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg      <= div_tab[DEF_SEL];
            half_reg     <= half_tab[DEF_SEL];
            cur_sel_reg  <= DEF_SEL;
            lock_reg     <= 1'b0;
            tx_cnt_reg   <= '0;
            tx_tick_reg  <= 1'b0;
            rx_cnt_reg   <= '0;
            rx_first_reg <= 1'b1;
            rx_tick_reg  <= 1'b0;
        end else begin
            if (!bus.tx_en && !bus.rx_en) begin
                div_reg     <= div_tab[bus.baud_sel];
                half_reg    <= half_tab[bus.baud_sel];
                cur_sel_reg <= bus.baud_sel;
            end
            lock_reg <= bus.tx_en | bus.rx_en;

            if (!bus.tx_en) begin
                tx_cnt_reg  <= '0;
                tx_tick_reg <= 1'b0;
            end else if (tx_cnt_reg == div_reg - CNT_W'(1)) begin
                tx_cnt_reg  <= '0;
                tx_tick_reg <= 1'b1;
            end else begin
                tx_cnt_reg  <= tx_cnt_reg + CNT_W'(1);
                tx_tick_reg <= 1'b0;
            end

            if (!bus.rx_en) begin
                rx_cnt_reg   <= '0;
                rx_first_reg <= 1'b1;
                rx_tick_reg  <= 1'b0;
            end else if (rx_cnt_reg == rx_target) begin
                rx_cnt_reg   <= '0;
                rx_first_reg <= 1'b0;
                rx_tick_reg  <= 1'b1;
            end else begin
                rx_cnt_reg   <= rx_cnt_reg + CNT_W'(1);
                rx_tick_reg  <= 1'b0;
            end
        end
    end

    assign bus.tx_tick   = tx_tick_reg;
    assign bus.rx_tick   = rx_tick_reg;
    assign bus.baud_lock = lock_reg;
    assign bus.cur_sel   = cur_sel_reg;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at 50 MHz: strobe spacing, rate locking,
// mid-frame enable drop and mid-frame reset.
module tb_uart_baud_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    uart_baud_gen_if bus ();

    uart_baud_gen #(
        .CLK_HZ      (50_000_000),
        .CNT_W       (16),
        .DEFAULT_SEL (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until the chosen strobe is seen high (sel 0 = tx, 1 = rx); -1 if never.
    task automatic wait_tick(input int sel, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 0 && bus.tx_tick === 1'b1) || (sel == 1 && bus.rx_tick === 1'b1)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_ticks(input int edges, output int ntx, output int nrx);
        ntx = 0;
        nrx = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_tick === 1'b1) ntx++;
            if (bus.rx_tick === 1'b1) nrx++;
        end
    endtask

    // Edge indices (from 1) of the first three strobes on each channel.
    task automatic track_both(input int edges, output int tx_at [3], output int rx_at [3]);
        int nt;
        int nr;
        nt = 0;
        nr = 0;
        for (int k = 0; k < 3; k++) begin
            tx_at[k] = -1;
            rx_at[k] = -1;
        end
        for (int i = 1; i <= edges; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_tick === 1'b1 && nt < 3) begin tx_at[nt] = i; nt++; end
            if (bus.rx_tick === 1'b1 && nr < 3) begin rx_at[nr] = i; nr++; end
        end
    endtask

    initial begin
        int n;
        int ntx;
        int nrx;
        int tx_at [3];
        int rx_at [3];

        bus.baud_sel = 3'd2;
        bus.tx_en    = 1'b0;
        bus.rx_en    = 1'b0;

        // Reset state
        step(3);
        check("rst_tx_tick", int'(bus.tx_tick), 0);
        check("rst_rx_tick", int'(bus.rx_tick), 0);
        check("rst_lock", int'(bus.baud_lock), 0);
        check("rst_cur_sel", int'(bus.cur_sel), 2);
        rst_n = 1'b1;
        step(2);

        // 9600 baud TX, 20000 cycles: exactly three pulses, 5208 apart
        bus.tx_en = 1'b1;
        wait_tick(0, 6000, n);  check("tx9600_first", n, 5208);
        wait_tick(0, 6000, n);  check("tx9600_second", n, 5208);
        wait_tick(0, 6000, n);  check("tx9600_third", n, 5208);
        count_ticks(20000 - 3 * 5208, ntx, nrx);
        check("tx9600_no_fourth", ntx, 0);
        check("tx9600_lock", int'(bus.baud_lock), 1);
        check("tx9600_cur_sel", int'(bus.cur_sel), 2);
        bus.tx_en = 1'b0;
        step(1);
        check("tx_off_lock", int'(bus.baud_lock), 0);

        // 115200 baud RX: half-bit then full-bit spacing
        bus.baud_sel = 3'd6;
        step(2);
        bus.rx_en = 1'b1;
        wait_tick(1, 1000, n);  check("rx115k_first", n, 217);
        wait_tick(1, 1000, n);  check("rx115k_second", n, 434);
        wait_tick(1, 1000, n);  check("rx115k_third", n, 434);
        check("rx115k_cur_sel", int'(bus.cur_sel), 6);
        check("rx115k_lock", int'(bus.baud_lock), 1);
        bus.rx_en = 1'b0;
        step(1);
        check("rx_off_tick", int'(bus.rx_tick), 0);

        // 230400 baud, both channels raised on the same edge
        bus.baud_sel = 3'd7;
        step(2);
        bus.tx_en = 1'b1;
        bus.rx_en = 1'b1;
        track_both(700, tx_at, rx_at);
        check("both_tx0", tx_at[0], 217);
        check("both_tx1", tx_at[1], 434);
        check("both_tx2", tx_at[2], 651);
        check("both_rx0", rx_at[0], 108);
        check("both_rx1", rx_at[1], 325);
        check("both_rx2", rx_at[2], 542);
        bus.tx_en = 1'b0;
        bus.rx_en = 1'b0;

        // Selection change while locked is ignored until both enables drop
        bus.baud_sel = 3'd2;
        step(2);
        bus.tx_en = 1'b1;
        step(1000);
        bus.baud_sel = 3'd4;
        wait_tick(0, 6000, n);  check("lock_tx_first", n, 4208);
        wait_tick(0, 6000, n);  check("lock_tx_second", n, 5208);
        check("lock_cur_sel", int'(bus.cur_sel), 2);
        bus.tx_en = 1'b0;
        step(1);
        bus.tx_en = 1'b1;
        wait_tick(0, 6000, n);  check("reload_tx_first", n, 1302);
        wait_tick(0, 6000, n);  check("reload_tx_second", n, 1302);
        check("reload_cur_sel", int'(bus.cur_sel), 4);
        bus.tx_en = 1'b0;

        // RX dropped mid-bit at rx_cnt=2000, re-raised 5 cycles later
        bus.baud_sel = 3'd2;
        step(2);
        bus.rx_en = 1'b1;
        count_ticks(2000, ntx, nrx);
        check("rxdrop_before", nrx, 0);
        bus.rx_en = 1'b0;
        count_ticks(5, ntx, nrx);
        check("rxdrop_gap", nrx, 0);
        bus.rx_en = 1'b1;
        wait_tick(1, 6000, n);  check("rxdrop_restart", n, 2604);
        bus.rx_en = 1'b0;

        // Reset pulse mid-frame with both channels running at 115200
        bus.baud_sel = 3'd6;
        step(2);
        check("pre_rst_cur_sel", int'(bus.cur_sel), 6);
        bus.tx_en = 1'b1;
        bus.rx_en = 1'b1;
        step(3000);
        rst_n = 1'b0;
        step(1);
        check("midrst_tx_tick", int'(bus.tx_tick), 0);
        check("midrst_rx_tick", int'(bus.rx_tick), 0);
        check("midrst_lock", int'(bus.baud_lock), 0);
        check("midrst_cur_sel", int'(bus.cur_sel), 2);
        rst_n = 1'b1;
        track_both(8000, tx_at, rx_at);
        check("postrst_tx0", tx_at[0], 5208);
        check("postrst_rx0", rx_at[0], 2604);
        check("postrst_rx1", rx_at[1], 7812);
        check("postrst_cur_sel", int'(bus.cur_sel), 2);
        bus.tx_en = 1'b0;
        bus.rx_en = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
